// File: rtl/boot_load_ctrl_if.sv
// Boot loader bundle: host word stream, data-memory write port and status.
// master = host/top side, slave = boot_load_ctrl.
interface boot_load_ctrl_if;
   logic        start;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        ld_last;
   logic        ld_ready;
   logic        cpu_reset;
   logic        mem_we;
   logic [31:0] mem_adr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_funct3;
   logic [15:0] word_count;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [31:0] csum;

   modport master (
      output start, ld_valid, ld_data, ld_last,
      input  ld_ready, cpu_reset, mem_we, mem_adr, mem_wdata, mem_funct3,
             word_count, busy, done, overflow, csum
   );

   modport slave (
      input  start, ld_valid, ld_data, ld_last,
      output ld_ready, cpu_reset, mem_we, mem_adr, mem_wdata, mem_funct3,
             word_count, busy, done, overflow, csum
   );
endinterface

// File: rtl/boot_load_ctrl.sv
// boot_load_ctrl: loads an image into data memory from a handshaked word
// stream while holding the CPU in reset, then releases the CPU after a
// fixed hold time. Optional feature: define BOOT_CHECKSUM_EN to get a
// wrapping 32-bit sum of accepted words on csum (tied to 0 otherwise).
module boot_load_ctrl #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 64,
   parameter int          RST_HOLD    = 4
) (
   input  logic         clk,
   input  logic         reset,
   boot_load_ctrl_if.slave bl
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_RUN  = 2'd3;

   localparam int          HW        = $clog2(RST_HOLD + 1);
   localparam logic [HW-1:0] HOLD_INIT = RST_HOLD[HW-1:0];
   localparam logic [15:0] DEPTH16   = DEPTH_WORDS[15:0];

   logic [1:0]    state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          we_q, we_d;
   logic [31:0]   adr_q, adr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          ovf_q, ovf_d;

   logic          accept;
   logic          start_ok;

   // Ready is a pure state decode; start is honoured only when no load/hold is in flight.
   assign accept   = bl.ld_valid && (state_q == S_LOAD);
   assign start_ok = bl.start && ((state_q == S_IDLE) || (state_q == S_RUN));

   // Next-state and datapath for the load sequence.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      we_d    = 1'b0;
      adr_d   = adr_q;
      wdata_d = wdata_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE, S_RUN: begin
            if (start_ok) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         S_LOAD: begin
            if (accept) begin
               we_d    = 1'b1;
               adr_d   = BASE_ADDR + {14'd0, cnt_q, 2'b00};
               wdata_d = bl.ld_data;
               cnt_d   = cnt_q + 16'd1;
               if (bl.ld_last) begin
                  state_d = S_HOLD;
                  hold_d  = HOLD_INIT;
               end else if (cnt_d == DEPTH16) begin
                  // Image larger than the window: stop and flag it.
                  ovf_d   = 1'b1;
                  state_d = S_HOLD;
                  hold_d  = HOLD_INIT;
               end
            end
         end
         default: begin
            // HOLD: count down so the final write commits before release.
            if (hold_q == '0) state_d = S_RUN;
            else              hold_d  = hold_q - HW'(1);
         end
      endcase
   end

   // State and datapath registers; reset drops any word presented alongside it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
         we_q    <= 1'b0;
         adr_q   <= BASE_ADDR;
         wdata_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         wdata_q <= wdata_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef BOOT_CHECKSUM_EN
   logic [31:0] csum_q, csum_d;

   // Wrapping sum of accepted words, cleared on each new load.
   always_comb begin
      csum_d = csum_q;
      if (start_ok)    csum_d = '0;
      else if (accept) csum_d = csum_q + bl.ld_data;
   end

   // Checksum register.
   always_ff @(posedge clk) begin
      if (reset) csum_q <= '0;
      else       csum_q <= csum_d;
   end

   assign bl.csum = csum_q;
`else
   assign bl.csum = 32'h0;
`endif

   assign bl.ld_ready   = (state_q == S_LOAD);
   assign bl.cpu_reset  = (state_q != S_RUN);
   assign bl.busy       = (state_q == S_LOAD) || (state_q == S_HOLD);
   assign bl.done       = (state_q == S_RUN);
   assign bl.mem_we     = we_q;
   assign bl.mem_adr    = adr_q;
   assign bl.mem_wdata  = wdata_q;
   assign bl.mem_funct3 = 3'b010;
   assign bl.word_count = cnt_q;
   assign bl.overflow   = ovf_q;

endmodule
